gf233_itinv: RTL
================

# gf233_itinv

Itoh-Tsujii inverter over GF(2^233), field polynomial f(x) = x^233 + x^74 + 1. It sits directly downstream of the Karatsuba multiplier and drives it as a shared resource: it consumes the multiplier's reduced 233-bit product to compute a^(-1) = a^(2^233 - 2). It uses one external multiply per chain step and one internal squaring per cycle. Affine-to-projective conversion and point-arithmetic sequencers use it.

## Interface
- Parameters:
  - M, 233: field degree (fixed; documents widths only)
- Ports:
  - clk  in  1  rising-edge clock
  - rst  in  1  synchronous, active-high reset
  - start  in  1  request; sampled only when busy=0
  - a_in  in  233  operand, captured on the start edge
  - busy  out  1  inversion in progress
  - done  out  1  one-cycle pulse, result valid
  - inv_out  out  233  a_in^(-1); holds until next accepted start
  - mul_a  out  233  multiplier operand A (zero-extended to 256 by the multiplier wrapper)
  - mul_b  out  233  multiplier operand B
  - mul_p  in  233  reduced product mul_a*mul_b mod f, combinational same cycle
- One clock; reset is synchronous and active-high.

## Operation
- Addition chain for m-1=232: 1,2,3,6,7,14,28,29,58,116,232. Let b_k = a^(2^k - 1). Step b_(k+j) = (b_k)^(2^j) * b_j.
- Step table (j, multiplicand):
  - (1,A), (1,A), (3,S), (1,A), (7,S), (14,S), (1,A), (29,S), (58,S), (116,S)
  - A = captured a_in; S = copy of T saved at step entry.
- Final: inv = b_232^2.
- Registers: A, T (accumulator), S, step index (0..9), square counter (7 bits), state.
- FSM states:
  - IDLE: on start, A<=a_in, T<=a_in, idx<=0, cnt<=SQ[0], S<=a_in, go SQR.
  - SQR: T<=sqr(T), cnt--. When cnt reaches 1, go MUL.
  - MUL: T<=mul_p, with mul_a=T and mul_b = A or S per table. If idx=9, go FIN; else idx++, cnt<=SQ[idx+1], S<=mul_p, go SQR.
  - FIN: T<=sqr(T), inv_out<=sqr(T), done<=1, go IDLE.
- mul_a/mul_b are 0 outside MUL.
- a_in=0 yields inv_out=0. No special case is needed; the chain produces it naturally.
- start while busy=1 is ignored with no queuing.
- Reset at any point: state IDLE, busy=0, done=0, inv_out=0, mul_a=mul_b=0, all internal registers 0. An in-flight operation is dropped.
- Squaring rule:
  - Spread bits: s[2i]=T[i], giving 465 bits.
  - Fold twice using x^233 = x^74 + 1: r = s[232:0] ^ s[464:233] ^ (s[464:233] << 74), truncated, then fold once more for bits above 232 from the shift.
  - Result is exact mod f.

## Timing
- E0 = edge sampling start=1 in IDLE.
- Edges E1..E242 perform 232 squarings and 10 multiplies (241 chain ops plus 1 final square).
- done=1 in the cycle after E242, for exactly one cycle. Latency is 242 cycles.
- busy=1 from after E0 until after E242. busy=0 in the same cycle done=1.
- A new start may be sampled in the done cycle.
- inv_out updates only at the FIN edge.
- Single-cycle multiply assumed. The critical path is T -> multiplier -> mul_p -> T.

## Structure
- Package gf233_pkg:
  - M=233, POLY_MID=74
  - state enum {IDLE,SQR,MUL,FIN}
  - constant arrays SQ_CNT[0:9]={1,1,3,1,7,14,1,29,58,116}
  - USE_A[0:9]={1,1,0,1,0,0,1,0,0,0}
- Sub-module gf233_sqr: combinational spread-and-fold squarer, 233 in and 233 out.
- The multiplier stays external. The top-level wires mul_a/mul_b/mul_p to the Karatsuba instance.

## Test plan
- a_in=1 -> inv_out=1, done exactly 242 cycles after start edge, busy high for 242 cycles.
- a_in=x (bit 1) -> inv_out has bits 232 and 73 set only.
- a_in=x^2 (bit 2) -> inv_out has bits 231 and 72 set only.
- a_in=0 -> inv_out=0, normal latency.
- start re-asserted at cycle 100 with a different a_in -> ignored, original result returned. rst at cycle 150 -> busy=0, done never pulses, inv_out=0. Then a fresh start completes correctly.
- 1000 random nonzero a_in with back-to-back starts on the done cycle -> software multiply of a_in by inv_out gives 1 for every run. Check mul_a=mul_b=0 in every non-MUL cycle.

Source files
------------

// File: rtl/gf233_pkg.sv
// gf233_pkg: field constants, FSM states and addition-chain step tables for the GF(2^233) inverter
package gf233_pkg;
  localparam int M = 233;
  localparam int POLY_MID = 74;
  typedef enum logic [1:0] {IDLE, SQR, MUL, FIN} state_t;
  localparam logic [6:0] SQ_CNT [0:9] = '{7'd1, 7'd1, 7'd3, 7'd1, 7'd7, 7'd14, 7'd1, 7'd29, 7'd58, 7'd116};
  localparam logic USE_A [0:9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
endpackage

// File: rtl/gf233_itinv_if.sv
// gf233_itinv_if: request/result and shared-multiplier signals of the inverter
interface gf233_itinv_if;
  import gf233_pkg::*;
  logic start;
  logic busy;
  logic done;
  logic [M-1:0] a_in;
  logic [M-1:0] inv_out;
  logic [M-1:0] mul_a;
  logic [M-1:0] mul_b;
  logic [M-1:0] mul_p;
  modport master (output start, a_in, mul_p, input busy, done, inv_out, mul_a, mul_b);
  modport slave (input start, a_in, mul_p, output busy, done, inv_out, mul_a, mul_b);
endinterface

// File: rtl/gf233_sqr.sv
// gf233_sqr: combinational squarer mod x^233 + x^74 + 1 (spread bits, then fold twice)
module gf233_sqr
  import gf233_pkg::*;
(
  input  logic [M-1:0] a,
  output logic [M-1:0] y
);
  logic [2*M-2:0] s;
  logic [305:0] t;
  logic [72:0] h;
  always_comb begin
    s = '0;
    for (int i = 0; i < M; i++) s[2*i] = a[i];
    t = {74'b0, s[2*M-2:M]} << POLY_MID;
    h = t[305:M];
    y = s[M-1:0] ^ {1'b0, s[2*M-2:M]} ^ t[M-1:0] ^ {160'b0, h} ^ ({160'b0, h} << POLY_MID);
  end
endmodule

// File: rtl/gf233_itinv.sv
// gf233_itinv: Itoh-Tsujii inverter over GF(2^233) driving an external single-cycle multiplier
module gf233_itinv
  import gf233_pkg::*;
(
  input logic clk,
  input logic rst,
  gf233_itinv_if.slave bus
);
  state_t state_q, state_d;
  logic [M-1:0] a_q, a_d, t_q, t_d, s_q, s_d, inv_q, inv_d, t_sq;
  logic [3:0] idx_q, idx_d;
  logic [6:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d;
  gf233_sqr u_sqr (.a(t_q), .y(t_sq));
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    t_d = t_q;
    s_d = s_q;
    inv_d = inv_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        a_d = bus.a_in;
        t_d = bus.a_in;
        s_d = bus.a_in;
        idx_d = 4'd0;
        cnt_d = SQ_CNT[0];
        busy_d = 1'b1;
        state_d = SQR;
      end
      SQR: begin
        t_d = t_sq;
        cnt_d = cnt_q - 7'd1;
        state_d = (cnt_q == 7'd1) ? MUL : SQR;
      end
      MUL: begin
        t_d = bus.mul_p;
        if (idx_q == 4'd9) state_d = FIN;
        else begin
          idx_d = idx_q + 4'd1;
          cnt_d = SQ_CNT[idx_q + 4'd1];
          s_d = bus.mul_p;
          state_d = SQR;
        end
      end
      FIN: begin
        t_d = t_sq;
        inv_d = t_sq;
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      t_q <= '0;
      s_q <= '0;
      inv_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      t_q <= t_d;
      s_q <= s_d;
      inv_q <= inv_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.mul_a = (state_q == MUL) ? t_q : '0;
  assign bus.mul_b = (state_q == MUL) ? (USE_A[idx_q] ? a_q : s_q) : '0;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.inv_out = inv_q;
endmodule
